// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Single-port word memory with a fixed number of wait states per
//             access, byte-lane writes and registered read data.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [3:0] LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  // Storage is zero at time zero and deliberately left out of reset.
  logic [31:0] storage [DEPTH] = '{default: 32'h0};

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] lat_idx_q, lat_idx_d;
  logic                  lat_re_q, lat_re_d;
  logic [3:0]            lat_we_q, lat_we_d;
  logic [31:0]           lat_din_q, lat_din_d;
  logic [31:0]           dout_q, dout_d;

  logic                  req;
  logic [DEPTH_LOG2-1:0] in_idx;
  logic                  perform;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_re;
  logic [3:0]            acc_we;
  logic [31:0]           acc_din;

  assign req    = re | (|we);
  assign in_idx = addr[DEPTH_LOG2+1:2];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      lat_idx_q <= '0;
      lat_re_q  <= 1'b0;
      lat_we_q  <= 4'd0;
      lat_din_q <= 32'h0;
      dout_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_idx_q <= lat_idx_d;
      lat_re_q  <= lat_re_d;
      lat_we_q  <= lat_we_d;
      lat_din_q <= lat_din_d;
      dout_q    <= dout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_idx_d = lat_idx_q;
    lat_re_d  = lat_re_q;
    lat_we_d  = lat_we_q;
    lat_din_d = lat_din_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req && (LATENCY != 0)) begin
          state_d   = ST_WAIT;
          cnt_d     = LAT_M1;
          lat_idx_d = in_idx;
          lat_re_d  = re;
          lat_we_d  = we;
          lat_din_d = din;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d  = ST_IDLE;
          lat_re_d = 1'b0;
          lat_we_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: stall and the access performed at the coming edge
  always_comb begin
    stall   = 1'b0;
    perform = 1'b0;
    acc_idx = in_idx;
    acc_re  = re;
    acc_we  = we;
    acc_din = din;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (LATENCY == 0) perform = 1'b1;
          else              stall   = 1'b1;
        end
      end
      ST_WAIT: begin
        acc_idx = lat_idx_q;
        acc_re  = lat_re_q;
        acc_we  = lat_we_q;
        acc_din = lat_din_q;
        if (cnt_q != 4'd0) stall   = 1'b1;
        else               perform = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      stall   = 1'b0;
      perform = 1'b0;
    end
  end

  // Reads sample the pre-write word, giving read-before-write ordering.
  always_comb begin
    dout_d = dout_q;
    if (perform && acc_re) dout_d = storage[acc_idx];
  end

  always_ff @(posedge clk) begin
    if (perform) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_we[i]) storage[acc_idx][8*i +: 8] <= acc_din[8*i +: 8];
      end
    end
  end

  assign dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Directed self-checking bench for mem_responder (LATENCY 2 and 0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, din, dout;
  logic        re, stall;
  logic [3:0]  we;
  logic [31:0] addr0, din0, dout0;
  logic        re0, stall0;
  logic [3:0]  we0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .re(re), .we(we),
    .din(din), .dout(dout), .stall(stall)
  );

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .addr(addr0), .re(re0), .we(we0),
    .din(din0), .dout(dout0), .stall(stall0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    re = 1'b0; we = 4'h0; addr = 32'h0; din = 32'h0;
  endtask

  // Presents one access on the LATENCY=2 instance, counts stall cycles,
  // and returns one cycle after the perform edge with inputs idle.
  task automatic access(input string tag, input logic r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d, input bit scramble);
    int n;
    n = 0;
    re = r; we = w; addr = a; din = d;
    #1;
    while (stall === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (scramble) begin
        addr = ~a; din = ~d; we = 4'hF; re = 1'b0;
      end
    end
    check({tag, " stall cycles"}, 32'(n), 32'd2);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  logic [31:0] vals [3] = '{32'h1111_A0A0, 32'h2222_B1B1, 32'h3333_C2C2};

  initial begin
    reset = 1'b1;
    idle_inputs();
    re0 = 1'b0; we0 = 4'h0; addr0 = 32'h0; din0 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset dout", dout, 32'h0);

    // Request during reset must be ignored
    we = 4'hF; addr = 32'h40; din = 32'h5555_5555;
    #1;
    check("stall while reset held", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    check("post-reset stall", {31'b0, stall}, 32'd0);

    access("wr 0x10", 1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    access("rd 0x10", 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    check("rd 0x10 dout", dout, 32'hDEADBEEF);

    access("byte wr", 1'b0, 4'b0010, 32'h10, 32'h0000AA00, 1'b0);
    check("dout held by write", dout, 32'hDEADBEEF);
    access("rd merged", 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    check("byte merge", dout, 32'hDEADAAEF);

    access("alias wr", 1'b0, 4'hF, 32'h0000_1004, 32'h12345678, 1'b1);
    access("alias rd", 1'b1, 4'h0, 32'h0000_0004, 32'h0, 1'b0);
    check("alias dout", dout, 32'h12345678);
    access("low bits rd", 1'b1, 4'h0, 32'h0000_0007, 32'h0, 1'b1);
    check("addr[1:0] ignored", dout, 32'h12345678);

    access("wr 0x20", 1'b0, 4'hF, 32'h20, 32'h1, 1'b0);
    access("rmw 0x20", 1'b1, 4'hF, 32'h20, 32'h2, 1'b0);
    check("rbw old word", dout, 32'h1);
    access("rd 0x20", 1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    check("rbw new word", dout, 32'h2);

    // Reset one cycle into WAIT of a write: the write must be dropped
    we = 4'hF; addr = 32'h30; din = 32'hCAFEF00D;
    #1;
    check("wr 0x30 stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("stall during reset", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    check("stall after reset", {31'b0, stall}, 32'd0);
    check("dout after reset", dout, 32'h0);
    access("rd 0x30", 1'b1, 4'h0, 32'h30, 32'h0, 1'b0);
    check("dropped write", dout, 32'h0);
    access("rd 0x10 kept", 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    check("storage kept over reset", dout, 32'hDEADAAEF);
    access("rd 0x40", 1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
    check("write in reset ignored", dout, 32'h0);

    // LATENCY=0 instance: back-to-back writes then reads
    for (int i = 0; i < 3; i++) begin
      re0 = 1'b0; we0 = 4'hF; addr0 = 32'(4 * i); din0 = vals[i];
      #1;
      check($sformatf("lat0 wr%0d stall", i), {31'b0, stall0}, 32'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      re0 = 1'b1; we0 = 4'h0; addr0 = 32'(4 * i); din0 = 32'h0;
      #1;
      check($sformatf("lat0 rd%0d stall", i), {31'b0, stall0}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("lat0 rd%0d dout", i), dout0, vals[i]);
    end
    re0 = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
